dm_sized: RTL

Parametrised byte-addressed data memory for the single-cycle/multicycle CPU datapath: little-endian, 32-bit port, byte/half/word access with sign or zero extension, misalignment detection, and a valid/ready request–response handshake with configurable read latency. It sits between the CPU load/store unit and the byte array and supersedes the fixed word-only data memory.

---
 rtl/dm_sized.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/dm_sized.sv
// dm_sized: byte-addressed little-endian data memory with sized,
// sign/zero-extended accesses and a latency-configurable handshake.
module dm_sized #(
   parameter int ADDR_W           = 10,
   parameter int LATENCY          = 1,
   parameter bit ALLOW_MISALIGNED = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err
);

   localparam int         DEPTH    = 1 << ADDR_W;
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic [31:0] hold_d;
   logic        hold_e;

   logic [7:0]  mem [DEPTH] = '{default: 8'h00};

   logic              accept;
   logic [3:0]        be;
   logic              misal;
   logic              bad;
   logic              err;
   logic [ADDR_W-1:0] ba [4];
   logic [7:0]        rb [4];
   logic [7:0]        wb [4];
   logic [31:0]       ext;
   logic [31:0]       ld;

   assign req_ready = rst_n & (state == IDLE);
   assign accept    = req_valid & req_ready;

   // byte lanes: addr+k wraps inside the ADDR_W-bit space
   for (genvar k = 0; k < 4; k++) begin : g_lane
      assign ba[k] = req_addr + ADDR_W'(k);
      assign rb[k] = mem[ba[k]];
      assign wb[k] = req_wdata[8*k +: 8];
   end

   // size decode: lane enables and alignment / legality
   always_comb begin
      be    = 4'b0000;
      misal = 1'b0;
      bad   = 1'b0;
      unique case (req_size)
         2'b00: be = 4'b0001;
         2'b01: begin
            be    = 4'b0011;
            misal = req_addr[0];
         end
         2'b10: begin
            be    = 4'b1111;
            misal = |req_addr[1:0];
         end
         default: bad = 1'b1;
      endcase
   end

   assign err = bad | (~ALLOW_MISALIGNED & misal);

   // load extension; stores and errors return zero
   always_comb begin
      ext = 32'h0;
      unique case (req_size)
         2'b00: ext = req_unsigned ? {24'h0, rb[0]}
                                   : {{24{rb[0][7]}}, rb[0]};
         2'b01: ext = req_unsigned ? {16'h0, rb[1], rb[0]}
                                   : {{16{rb[1][7]}}, rb[1], rb[0]};
         2'b10: ext = {rb[3], rb[2], rb[1], rb[0]};
         default: ext = 32'h0;
      endcase
      ld = (err | req_we) ? 32'h0 : ext;
   end

   // byte array write; contents survive rst_n
   always_ff @(posedge clk) begin
      if (accept & req_we & ~err) begin
         for (int k = 0; k < 4; k++) begin
            if (be[k]) mem[ba[k]] <= wb[k];
         end
      end
   end

   // request/response sequencing with registered response outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         hold_d    <= 32'h0;
         hold_e    <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'h0;
         rsp_err   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  hold_d <= ld;
                  hold_e <= err;
                  if (LATENCY <= 1) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_rdata <= ld;
                     rsp_err   <= err;
                  end else begin
                     state <= WAIT;
                     cnt   <= CNT_INIT;
                  end
               end
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt <= 4'd1) begin
                  state     <= RESP;
                  cnt       <= 4'd0;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= hold_d;
                  rsp_err   <= hold_e;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  rsp_rdata <= 32'h0;
                  rsp_err   <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
